// File: rtl/scan_wrap_ctrl.sv
// scan_wrap_ctrl: scan-chain wrapper controller with a capture/shift/update
// sequence and an optional multiple-input signature register (MISR).
//
// Parameters:
//   WIDTH  number of scan cells in the chain (2..256)
//   POLY   MISR feedback polynomial (WIDTH bits)
//
// Ports:
//   CK             clock, all state changes on the rising edge
//   RST            asynchronous active-high reset
//   start          request a capture/shift/update operation (ignored if busy)
//   abort          cancel an operation in CAPTURE or SHIFT
//   scan_data_in   serial data entering chain cell 0
//   d              parallel functional data captured into the chain
//   misr_clr       synchronous clear of the signature register
//   q              update register driving the functional logic
//   scan_data_out  chain cell WIDTH-1
//   busy           high in any non-IDLE state
//   done           high exactly in UPDATE
//   sig            MISR signature (tied to 0 without the MISR)
//
// Build option:
//   SCAN_MISR_EN   when defined, a MISR folds d in at every CAPTURE edge.
//                  When undefined there are no MISR flops, sig reads 0 and
//                  misr_clr has no effect.

module scan_wrap_ctrl #(
    parameter int              WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY = 'h002D
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic             scan_data_in,
    input  logic [WIDTH-1:0] d,
    input  logic             misr_clr,
    output logic [WIDTH-1:0] q,
    output logic             scan_data_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sig
);

    // One extra bit so the counter can reach WIDTH without wrapping.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SHIFT,
        UPDATE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] chain;
    logic [CW-1:0]    cnt;

    assign scan_data_out = chain[WIDTH-1];

    // busy/done are registered alongside the state so they change on
    // the same edge as the state they describe.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            chain <= '0;
            cnt   <= '0;
            q     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // abort has no meaning here, start alone decides
                    if (start) begin
                        state <= CAPTURE;
                        busy  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        chain <= d;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // abort wins over the shift-complete transition
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        chain <= {chain[WIDTH-2:0], scan_data_in};
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= UPDATE;
                            done  <= 1'b1;
                        end
                    end
                end
                UPDATE: begin
                    q     <= chain;
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCAN_MISR_EN
    logic [WIDTH-1:0] misr;
    logic [WIDTH-1:0] misr_fb;

    assign misr_fb = misr[WIDTH-1] ? POLY : '0;

    // An aborted CAPTURE loads nothing, so it leaves the signature alone.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            misr <= '0;
        end else if (misr_clr) begin
            misr <= '0;
        end else if (state == CAPTURE && !abort) begin
            misr <= {misr[WIDTH-2:0], 1'b0} ^ misr_fb ^ d;
        end
    end

    assign sig = misr;
`else
    localparam logic [WIDTH-1:0] unused_poly = POLY;
    logic unused_misr_clr;

    assign unused_misr_clr = misr_clr;
    assign sig = '0;
`endif

endmodule

// File: tb/tb_scan_wrap_ctrl.sv
// tb_scan_wrap_ctrl: directed scoreboard bench for scan_wrap_ctrl (WIDTH=8).
// Stimulus queues expectations; a monitor checks them as the DUT responds.

module tb_scan_wrap_ctrl;

    localparam int W = 8;

`ifdef SCAN_MISR_EN
    localparam bit MISR = 1'b1;
`else
    localparam bit MISR = 1'b0;
`endif

    logic         CK = 1'b0;
    logic         RST = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         scan_data_in = 1'b0;
    logic [W-1:0] d = '0;
    logic         misr_clr = 1'b0;
    logic [W-1:0] q;
    logic         scan_data_out;
    logic         busy;
    logic         done;
    logic [W-1:0] sig;

    scan_wrap_ctrl #(
        .WIDTH(W),
        .POLY (8'h1D)
    ) dut (
        .CK           (CK),
        .RST          (RST),
        .start        (start),
        .abort        (abort),
        .scan_data_in (scan_data_in),
        .d            (d),
        .misr_clr     (misr_clr),
        .q            (q),
        .scan_data_out(scan_data_out),
        .busy         (busy),
        .done         (done),
        .sig          (sig)
    );

    always #5 CK = ~CK;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] sig;
        bit           chk_sig;
        int           gap;
    } exp_t;

    exp_t doneq[$];
    logic bitq[$];
    int   lenq[$];

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // sig_known: a hand value exists for the MISR build; without the
    // MISR the signature is always expected to read zero.
    task automatic push_done(input logic [W-1:0] eq, input logic [W-1:0] es,
                             input bit sig_known, input int gap);
        exp_t e;
        e.q       = eq;
        e.sig     = MISR ? es : '0;
        e.chk_sig = sig_known || !MISR;
        e.gap     = gap;
        doneq.push_back(e);
    endtask

    task automatic push_bits(input logic [W-1:0] v);
        logic [W-1:0] t;
        t = v;
        for (int i = W - 1; i >= 0; i--) bitq.push_back(t[i]);
    endtask

    task automatic pulse_start();
        @(negedge CK);
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge CK);
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge CK);
    endtask

    // Monitor: serial bits in SHIFT, busy run length, done pulse,
    // signature at done, and q one edge after done.
    initial begin
        int   run;
        int   last;
        int   cyc;
        logic b;
        exp_t e;
        run  = 0;
        last = 0;
        cyc  = 0;
        forever begin
            @(negedge CK);
            cyc++;
            if (busy) begin
                if (run >= 1 && run <= W && bitq.size() > 0) begin
                    b = bitq.pop_front();
                    check("scan_out", {31'd0, scan_data_out}, {31'd0, b});
                end
                run++;
            end else if (run > 0) begin
                if (lenq.size() > 0) check("busy_len", run, lenq.pop_front());
                else check("busy_len_unexpected", run, 32'd0);
                run = 0;
            end
            if (done) begin
                if (doneq.size() == 0) begin
                    check("done_unexpected", {31'd0, done}, 32'd0);
                end else begin
                    e = doneq.pop_front();
                    if (e.chk_sig) check("sig_at_done", sig, e.sig);
                    if (e.gap != 0) check("done_gap", cyc - last, e.gap);
                    @(posedge CK);
                    #1;
                    check("q_update", q, e.q);
                    check("done_one_cycle", {31'd0, done}, 32'd0);
                end
                last = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state, checked while reset is still asserted
        #1;
        check("rst_q", q, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sdo", {31'd0, scan_data_out}, 32'd0);
        check("rst_sig", sig, 32'd0);
        repeat (2) @(negedge CK);
        RST = 1'b0;
        repeat (2) @(negedge CK);

        // A5 shifted out MSB first, ones shifted in
        d = 8'hA5;
        scan_data_in = 1'b1;
        push_bits(8'hA5);
        push_done(8'hFF, '0, 1'b0, 0);
        lenq.push_back(10);
        pulse_start();
        wait_idle();

        // abort after three shifts: five busy cycles, q holds, no done
        d = 8'h3C;
        scan_data_in = 1'b0;
        lenq.push_back(5);
        pulse_start();
        repeat (4) @(negedge CK);
        abort = 1'b1;
        @(negedge CK);
        abort = 1'b0;
        check("abort_idle", {31'd0, busy}, 32'd0);
        wait_idle();
        check("abort_q_hold", q, 32'h0000_00FF);

        // start re-pulsed mid-SHIFT is ignored: one done, 10 busy cycles
        d = 8'h5A;
        scan_data_in = 1'b0;
        push_done(8'h00, '0, 1'b0, 0);
        lenq.push_back(10);
        pulse_start();
        repeat (4) @(negedge CK);
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
        wait_idle();

        // clear the signature
        misr_clr = 1'b1;
        @(negedge CK);
        misr_clr = 1'b0;
        check("misr_clr", sig, 32'd0);

        // start held high: three ops, done every 11 cycles, sig 01/03/07
        d = 8'h01;
        scan_data_in = 1'b1;
        push_done(8'hFF, 8'h01, 1'b1, 0);
        push_done(8'hFF, 8'h03, 1'b1, 11);
        push_done(8'hFF, 8'h07, 1'b1, 11);
        lenq.push_back(10);
        lenq.push_back(10);
        lenq.push_back(10);
        @(negedge CK);
        start = 1'b1;
        repeat (23) @(negedge CK);
        start = 1'b0;
        wait_idle();

        // reset mid-SHIFT clears everything without a clock edge
        d = 8'hC3;
        scan_data_in = 1'b0;
        lenq.push_back(4);
        pulse_start();
        repeat (3) @(negedge CK);
        @(posedge CK);
        #2;
        RST = 1'b1;
        #1;
        check("mid_rst_q", q, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_sdo", {31'd0, scan_data_out}, 32'd0);
        check("mid_rst_sig", sig, 32'd0);
        @(negedge CK);
        @(negedge CK);
        RST = 1'b0;
        repeat (2) @(negedge CK);

        // first op after reset, with start and abort together in IDLE
        d = 8'h96;
        scan_data_in = 1'b1;
        push_bits(8'h96);
        push_done(8'hFF, 8'h96, 1'b1, 0);
        lenq.push_back(10);
        @(negedge CK);
        start = 1'b1;
        abort = 1'b1;
        @(negedge CK);
        start = 1'b0;
        abort = 1'b0;
        wait_idle();

        check("doneq_drained", doneq.size(), 32'd0);
        check("bitq_drained", bitq.size(), 32'd0);
        check("lenq_drained", lenq.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/scan_wrap_ctrl.md
SCAN_WRAP_CTRL -- requirements
Module: scan_wrap_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning number of scan cells in the chain (2..256).
REQ-002 SHALL have parameter POLY, default 16'h002D (WIDTH bits), meaning MISR feedback polynomial.
REQ-003 SHALL have port CK, input, 1, meaning the single clock; all state changes on rising edge.
REQ-004 SHALL have port RST, input, 1, meaning reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1, meaning request for a capture/shift/update operation.
REQ-006 SHALL have port abort, input, 1, meaning cancel an operation in progress.
REQ-007 SHALL have port scan_data_in, input, 1, meaning serial data entering chain cell 0.
REQ-008 SHALL have port d, input, WIDTH, meaning parallel functional data to capture.
REQ-009 SHALL have port misr_clr, input, 1, meaning synchronous clear of the signature register.
REQ-010 SHALL have port q, output, WIDTH, meaning the update register driving the functional logic.
REQ-011 SHALL have port scan_data_out, output, 1, meaning chain cell WIDTH-1.
REQ-012 SHALL have ports busy (output, 1, high in any non-IDLE state) and done (output, 1, high exactly in UPDATE).
REQ-013 SHALL have port sig, output, WIDTH, meaning the MISR signature.

Function
REQ-014 SHALL implement FSM states IDLE, CAPTURE, SHIFT, UPDATE.
REQ-015 IDLE: start=1 at an edge SHALL move to CAPTURE; chain and q SHALL hold.
REQ-016 CAPTURE (exactly 1 cycle): at the edge, chain SHALL load d, shift counter SHALL clear to 0, and state SHALL move to SHIFT.
REQ-017 SHIFT: each edge SHALL move chain[i] into chain[i+1], load scan_data_in into chain[0], and increment the counter; the WIDTH-th shift edge (counter==WIDTH-1) SHALL move to UPDATE.
REQ-018 The counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL never wrap within one operation.
REQ-019 UPDATE (exactly 1 cycle): at the edge, q SHALL load chain and state SHALL return to IDLE.
REQ-020 Latency: start sampled at edge 0 SHALL give done high in the cycle after edge WIDTH+1, with the new q valid after edge WIDTH+2.
REQ-021 scan_data_out SHALL equal chain[WIDTH-1] combinationally; the first shifted-out bit is d[WIDTH-1] during the first SHIFT cycle.
REQ-022 start while busy SHALL be ignored; no queuing.
REQ-023 abort=1 in CAPTURE or SHIFT SHALL return to IDLE at that edge with q unchanged and no done; abort SHALL take priority over the shift-complete transition; abort in UPDATE or IDLE SHALL be ignored.
REQ-024 start and abort both high in IDLE SHALL start the operation (abort ignored in IDLE).

Reset
REQ-025 RST=1 SHALL immediately force state=IDLE, chain=0, counter=0, q=0, sig=0, so that busy=0, done=0, scan_data_out=0, including mid-operation.
REQ-026 After RST deasserts, the first start SHALL behave as in REQ-015 with no residual state.

Configuration
REQ-027 Macro SCAN_MISR_EN defined: at each CAPTURE edge, misr SHALL load {misr[WIDTH-2:0],1'b0} ^ (misr[WIDTH-1] ? POLY : 0) ^ d; misr_clr SHALL zero it (priority over update); sig=misr.
REQ-028 Macro SCAN_MISR_EN undefined: no MISR flops; sig SHALL be tied to 0 and misr_clr ignored; ports unchanged.

Verification (WIDTH=8 unless stated)
REQ-029 Assert RST mid-run -> q=00, busy=0, done=0, scan_data_out=0 without a clock edge.
REQ-030 d=8'hA5, scan_data_in=1, start pulse -> scan_data_out over 8 SHIFT cycles = 1,0,1,0,0,1,0,1; done for 1 cycle after edge 9; q=8'hFF.
REQ-031 d=8'h3C, scan_data_in=0, abort after 3 shifts -> IDLE next cycle, q keeps its prior value, done never asserted.
REQ-032 start re-pulsed during SHIFT -> exactly one done; total busy duration 10 cycles.
REQ-033 SCAN_MISR_EN, POLY=8'h1D, misr_clr, then two operations with d=8'h01 -> sig=8'h01, then 8'h03; without macro sig=00 throughout.
REQ-034 Back-to-back: start held high continuously -> new operation begins the cycle after UPDATE, done every 11 cycles.
